exp_lut_loader: RTL
===================

// Module: exp_lut_loader
// PURPOSE
//  Writer side of the exposure-curve LUT: takes 46 knot values from the config path over a
//  valid/ready stream into a shadow bank. Checks that the curve is non-increasing (the
//  interpolator computes OL-off*(OL-OH)>>2 unsigned). Copies shadow to the active bank at
//  frame_start, so the y1_0..y1_45 knots driven to the exp interpolator never change mid-frame.
// PARAMETERS
//  DW_Y    9    knot/output data width
//  N_KNOT  46   number of knots (indices 0..N_KNOT-1)
//  RST_Y   121  reset value of every active knot (flat curve, matches interpolator default)
// PORTS
//  clk          in   1       system clock
//  rst_n        in   1       asynchronous active-low reset
//  wr_start     in   1       pulse: abort any load, restart at knot 0
//  wr_valid     in   1       knot word valid
//  wr_data      in   DW_Y    knot value, sent in order y1_0 first
//  wr_ready     out  1       loader accepts word (transfer = wr_valid & wr_ready)
//  frame_start  in   1       1-cycle frame-boundary pulse (vsync domain, already synced)
//  tbl_pend     out  1       shadow bank complete and valid, waiting for frame_start
//  swap_done    out  1       1-cycle pulse: active bank updated
//  mono_err     out  1       sticky: last load rejected (y[k] > y[k-1]); cleared by wr_start
//  load_idx     out  6       next knot index to be written
//  y1_0..y1_45  out  DW_Y    active knots, registered, to exp interpolator
// BEHAVIOUR
//  Reset: active knots=RST_Y, shadow=0, state IDLE, wr_ready=0, tbl_pend=0, swap_done=0,
//   mono_err=0, load_idx=0.
//  FSM IDLE -> LOAD on wr_start. In LOAD, wr_ready=1. Each transfer writes shadow[load_idx]
//   and increments load_idx. The transfer of knot N_KNOT-1 gives -> PEND if no violation,
//   else -> ERR. PEND -> IDLE on frame_start (swap). ERR -> LOAD on wr_start.
//  Mono check: for k>=1, if wr_data > shadow[k-1], latch a violation flag. The word is still
//   stored and the load still runs to N_KNOT words. At load end with the flag set: mono_err=1,
//   state ERR, no swap ever happens from this load. Equal neighbours are legal.
//  Swap: frame_start while state==PEND. On the next edge, all active knots <= shadow, and
//   swap_done=1 for exactly that cycle. tbl_pend=1 only in PEND. wr_ready=0 in IDLE/PEND/ERR.
//  Latency: last transfer at cycle t -> tbl_pend=1 at t+1. frame_start at cycle f ->
//   new y1_* and swap_done visible at f+1.
//  Simultaneous events:
//   - wr_start has top priority: wr_ready=0 that cycle, word dropped, load_idx->0,
//     violation/mono_err cleared, state LOAD, pending table discarded (no swap even if
//     frame_start coincides).
//   - frame_start in the same cycle as the last transfer: no swap; table waits for the next
//     frame_start.
//   - frame_start outside PEND: ignored. Active bank holds its value.
//  wr_start mid-load: partial shadow is abandoned. Active bank is untouched.
//  Reset mid-load or in PEND: everything returns to reset values. Active knots = RST_Y.
//  load_idx saturates at N_KNOT-1 internally. It is never written past the last knot.
// STRUCTURE
//  Shared header exp_lut_defs.vh: DW_Y, N_KNOT, RST_Y defaults, and state encodings
//   (IDLE, LOAD, PEND, ERR).
//  Single module with no sub-modules. Shadow and active banks are flat regs of
//   N_KNOT*DW_Y bits. y1_k is a slice of the active bank.
//  Last-word compare uses a registered prev_data (shadow[k-1]), not a mux over the bank.
// TESTING
//  1. Reset, then read y1_0..y1_45 -> all 121; tbl_pend=0, wr_ready=0.
//  2. wr_start; send 46 words 450,440,...,0 (step 10) back-to-back -> tbl_pend=1 one cycle
//     after the last transfer; frame_start -> next cycle y1_0=450, y1_45=0, swap_done=1 for
//     1 cycle.
//  3. Load with y1_10=300 > y1_9=200, all others decreasing -> mono_err=1, state ERR;
//     frame_start -> y1_* unchanged (121), swap_done=0.
//  4. Load 20 words, wr_start, then a full valid load -> load_idx=0 after the restart;
//     swap yields only the second table.
//  5. frame_start coincident with the 46th transfer -> no swap; the next frame_start swaps.
//  6. Random wr_valid gaps (50%) plus wr_start coincident with wr_valid -> that word is
//     dropped, load_idx=0; the scoreboard matches the final active bank.

Source files
------------

// File: rtl/exp_lut_loader_pkg.sv
// Shared definitions for the exposure-curve LUT loader: default widths,
// knot count, reset knot value and the loader state encoding.
package exp_lut_loader_pkg;

  localparam int DW_Y_DEF   = 9;
  localparam int N_KNOT_DEF = 46;
  localparam int RST_Y_DEF  = 121;
  localparam int IDX_W      = 6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_PEND = 2'd2,
    ST_ERR  = 2'd3
  } state_e;

endpackage

// File: rtl/exp_lut_loader.sv
// exp_lut_loader: writer side of the exposure-curve LUT.
// Knot words arrive over a valid/ready stream into a shadow bank, the curve
// is checked to be non-increasing, and a good table is copied to the active
// bank at the next frame_start so the interpolator never sees a mid-frame change.
//
// Ports
//   clk, rst_n          clock, async active-low reset
//   wr_start            restart load at knot 0 (highest priority)
//   wr_valid/wr_data    knot stream, y1_0 first; wr_ready is the accept
//   frame_start         frame boundary pulse, triggers the bank swap
//   tbl_pend            good shadow table waiting for frame_start
//   swap_done           1-cycle pulse when the active bank was updated
//   mono_err            sticky: last load had y[k] > y[k-1]
//   load_idx            next knot index to be written (saturates at N_KNOT-1)
//   y1_0..y1_45         active knots, registered
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | no load in progress, active bank stable
// LOAD  | accepting knot words into the shadow bank
// PEND  | shadow complete and monotonic, waiting for frame_start
// ERR   | last load violated monotonicity, waits for wr_start
module exp_lut_loader
  import exp_lut_loader_pkg::*;
#(
  parameter int DW_Y   = DW_Y_DEF,
  parameter int N_KNOT = N_KNOT_DEF,   // output ports are fixed at 46 knots
  parameter int RST_Y  = RST_Y_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_start,
  input  logic             wr_valid,
  input  logic [DW_Y-1:0]  wr_data,
  output logic             wr_ready,
  input  logic             frame_start,
  output logic             tbl_pend,
  output logic             swap_done,
  output logic             mono_err,
  output logic [IDX_W-1:0] load_idx,
  output logic [DW_Y-1:0]  y1_0,  y1_1,  y1_2,  y1_3,  y1_4,  y1_5,  y1_6,  y1_7,
  output logic [DW_Y-1:0]  y1_8,  y1_9,  y1_10, y1_11, y1_12, y1_13, y1_14, y1_15,
  output logic [DW_Y-1:0]  y1_16, y1_17, y1_18, y1_19, y1_20, y1_21, y1_22, y1_23,
  output logic [DW_Y-1:0]  y1_24, y1_25, y1_26, y1_27, y1_28, y1_29, y1_30, y1_31,
  output logic [DW_Y-1:0]  y1_32, y1_33, y1_34, y1_35, y1_36, y1_37, y1_38, y1_39,
  output logic [DW_Y-1:0]  y1_40, y1_41, y1_42, y1_43, y1_44, y1_45
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_KNOT - 1);
  localparam logic [DW_Y-1:0]  RST_WORD = DW_Y'(RST_Y);

  state_e                   state_q, state_d;
  logic [IDX_W-1:0]         load_idx_q, load_idx_d;
  logic                     viol_q, viol_d;
  logic [DW_Y-1:0]          prev_data_q, prev_data_d;
  logic [N_KNOT*DW_Y-1:0]   shadow_q, shadow_d;
  logic [N_KNOT*DW_Y-1:0]   active_q, active_d;
  logic                     swap_done_q, swap_done_d;
  logic                     mono_err_q, mono_err_d;
  logic                     viol_now;

  // wr_start drops any word offered in the same cycle.
  assign wr_ready  = (state_q == ST_LOAD) && !wr_start;
  assign tbl_pend  = (state_q == ST_PEND);
  assign swap_done = swap_done_q;
  assign mono_err  = mono_err_q;
  assign load_idx  = load_idx_q;

  always_comb begin
    state_d     = state_q;
    load_idx_d  = load_idx_q;
    viol_d      = viol_q;
    prev_data_d = prev_data_q;
    shadow_d    = shadow_q;
    active_d    = active_q;
    swap_done_d = 1'b0;
    mono_err_d  = mono_err_q;
    viol_now    = viol_q;

    if (wr_start) begin
      state_d    = ST_LOAD;
      load_idx_d = '0;
      viol_d     = 1'b0;
      mono_err_d = 1'b0;
    end else begin
      case (state_q)
        ST_LOAD: begin
          if (wr_valid) begin
            shadow_d[int'(load_idx_q)*DW_Y +: DW_Y] = wr_data;
            prev_data_d = wr_data;
            // prev_data_q holds knot k-1; knot 0 has no predecessor.
            viol_now = viol_q || ((load_idx_q != '0) && (wr_data > prev_data_q));
            viol_d   = viol_now;
            if (load_idx_q == LAST_IDX) begin
              state_d    = viol_now ? ST_ERR : ST_PEND;
              mono_err_d = viol_now;
            end else begin
              load_idx_d = load_idx_q + IDX_W'(1);
            end
          end
        end
        ST_PEND: begin
          if (frame_start) begin
            active_d    = shadow_q;
            swap_done_d = 1'b1;
            state_d     = ST_IDLE;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      load_idx_q  <= '0;
      viol_q      <= 1'b0;
      prev_data_q <= '0;
      shadow_q    <= '0;
      active_q    <= {N_KNOT{RST_WORD}};
      swap_done_q <= 1'b0;
      mono_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      load_idx_q  <= load_idx_d;
      viol_q      <= viol_d;
      prev_data_q <= prev_data_d;
      shadow_q    <= shadow_d;
      active_q    <= active_d;
      swap_done_q <= swap_done_d;
      mono_err_q  <= mono_err_d;
    end
  end

  assign y1_0  = active_q[ 0*DW_Y +: DW_Y];
  assign y1_1  = active_q[ 1*DW_Y +: DW_Y];
  assign y1_2  = active_q[ 2*DW_Y +: DW_Y];
  assign y1_3  = active_q[ 3*DW_Y +: DW_Y];
  assign y1_4  = active_q[ 4*DW_Y +: DW_Y];
  assign y1_5  = active_q[ 5*DW_Y +: DW_Y];
  assign y1_6  = active_q[ 6*DW_Y +: DW_Y];
  assign y1_7  = active_q[ 7*DW_Y +: DW_Y];
  assign y1_8  = active_q[ 8*DW_Y +: DW_Y];
  assign y1_9  = active_q[ 9*DW_Y +: DW_Y];
  assign y1_10 = active_q[10*DW_Y +: DW_Y];
  assign y1_11 = active_q[11*DW_Y +: DW_Y];
  assign y1_12 = active_q[12*DW_Y +: DW_Y];
  assign y1_13 = active_q[13*DW_Y +: DW_Y];
  assign y1_14 = active_q[14*DW_Y +: DW_Y];
  assign y1_15 = active_q[15*DW_Y +: DW_Y];
  assign y1_16 = active_q[16*DW_Y +: DW_Y];
  assign y1_17 = active_q[17*DW_Y +: DW_Y];
  assign y1_18 = active_q[18*DW_Y +: DW_Y];
  assign y1_19 = active_q[19*DW_Y +: DW_Y];
  assign y1_20 = active_q[20*DW_Y +: DW_Y];
  assign y1_21 = active_q[21*DW_Y +: DW_Y];
  assign y1_22 = active_q[22*DW_Y +: DW_Y];
  assign y1_23 = active_q[23*DW_Y +: DW_Y];
  assign y1_24 = active_q[24*DW_Y +: DW_Y];
  assign y1_25 = active_q[25*DW_Y +: DW_Y];
  assign y1_26 = active_q[26*DW_Y +: DW_Y];
  assign y1_27 = active_q[27*DW_Y +: DW_Y];
  assign y1_28 = active_q[28*DW_Y +: DW_Y];
  assign y1_29 = active_q[29*DW_Y +: DW_Y];
  assign y1_30 = active_q[30*DW_Y +: DW_Y];
  assign y1_31 = active_q[31*DW_Y +: DW_Y];
  assign y1_32 = active_q[32*DW_Y +: DW_Y];
  assign y1_33 = active_q[33*DW_Y +: DW_Y];
  assign y1_34 = active_q[34*DW_Y +: DW_Y];
  assign y1_35 = active_q[35*DW_Y +: DW_Y];
  assign y1_36 = active_q[36*DW_Y +: DW_Y];
  assign y1_37 = active_q[37*DW_Y +: DW_Y];
  assign y1_38 = active_q[38*DW_Y +: DW_Y];
  assign y1_39 = active_q[39*DW_Y +: DW_Y];
  assign y1_40 = active_q[40*DW_Y +: DW_Y];
  assign y1_41 = active_q[41*DW_Y +: DW_Y];
  assign y1_42 = active_q[42*DW_Y +: DW_Y];
  assign y1_43 = active_q[43*DW_Y +: DW_Y];
  assign y1_44 = active_q[44*DW_Y +: DW_Y];
  assign y1_45 = active_q[45*DW_Y +: DW_Y];

endmodule
